ctrl_pipe: RTL

//  LEGv8 control unit for the 5-stage pipeline: decodes the ID-stage opcode and carries control bits through ID/EX, EX/MEM, MEM/WB.

---
 rtl/ctrl_pipe.sv | 249 ++++++++++++++++++++++++
 1 files changed

// File: rtl/ctrl_pipe.sv
// ctrl_pipe -- LEGv8 pipeline control unit.
//
// Decodes the ID-stage opcode into control bits. It then carries those bits,
// the destination register and an illegal-opcode tag through the ID/EX,
// EX/MEM and MEM/WB control registers. The datapath registers its data in
// parallel with this block.
//
// Load-use hazards are detected combinationally. A stall holds PC and IF/ID
// and sends a bubble into EX. A taken branch resolved in MEM (flush) turns
// the two younger stages into bubbles.
//
// Ports:
//   clk, reset        rising-edge clock, synchronous active-high reset
//   Op                ID instr[31:21]
//   id_rn/id_rm/id_rd ID register fields (Rn, Rm, Rd/Rt)
//   flush             branch taken, resolved in MEM
//   Reg2Loc           ID, combinational: 2nd read register is Rd (1) or Rm (0)
//   stall             combinational: hold PC and IF/ID, bubble into EX
//   ex_*              EX-stage ALUSrc, ALUOp, MemRead and destination register
//   mem_*             MEM-stage MemRead, MemWrite, Branch, Uncond, BrNot, rd
//   wb_*              WB-stage RegWrite, MemtoReg, rd
//   illegal           registered: opcode now in EX matched no decode entry

module ctrl_pipe #(
   parameter int unsigned REG_W    = 5,
   parameter int unsigned ZERO_REG = 31,
   parameter bit          EXT_ISA  = 1'b1,
   parameter bit          STALL_EN = 1'b1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [10:0]      Op,
   input  logic [REG_W-1:0] id_rn,
   input  logic [REG_W-1:0] id_rm,
   input  logic [REG_W-1:0] id_rd,
   input  logic             flush,
   output logic             Reg2Loc,
   output logic             stall,
   output logic             ex_ALUSrc,
   output logic [1:0]       ex_ALUOp,
   output logic             ex_MemRead,
   output logic [REG_W-1:0] ex_rd,
   output logic             mem_MemRead,
   output logic             mem_MemWrite,
   output logic             mem_Branch,
   output logic             mem_Uncond,
   output logic             mem_BrNot,
   output logic [REG_W-1:0] mem_rd,
   output logic             wb_RegWrite,
   output logic             wb_MemtoReg,
   output logic [REG_W-1:0] wb_rd,
   output logic             illegal
);

   localparam logic [REG_W-1:0] ZR = REG_W'(ZERO_REG);

   typedef struct packed {
      logic       mem_to_reg;
      logic       reg_write;
      logic       mem_read;
      logic       mem_write;
      logic       branch;
      logic       alu_src;
      logic [1:0] alu_op;
      logic       uncond;
      logic       br_not;
   } ctrl_t;

   // Each stage keeps only the fields that a later stage still consumes.
   typedef struct packed {
      ctrl_t            ctrl;
      logic [REG_W-1:0] rd;
      logic             illegal;
   } ex_stage_t;

   typedef struct packed {
      logic             mem_to_reg;
      logic             reg_write;
      logic             mem_read;
      logic             mem_write;
      logic             branch;
      logic             uncond;
      logic             br_not;
      logic [REG_W-1:0] rd;
   } mem_stage_t;

   typedef struct packed {
      logic             mem_to_reg;
      logic             reg_write;
      logic [REG_W-1:0] rd;
   } wb_stage_t;

   // A bubble carries no control and targets XZR, so it can never be a
   // hazard source or write a register.
   localparam ex_stage_t  EX_BUBBLE  = '{ctrl: '0, rd: ZR, illegal: 1'b0};
   localparam mem_stage_t MEM_BUBBLE = '{rd: ZR, default: 1'b0};
   localparam wb_stage_t  WB_BUBBLE  = '{rd: ZR, default: 1'b0};

   ctrl_t            dec_ctrl;
   logic             dec_reg2loc;
   logic             dec_illegal;
   logic             uses_rn;
   logic             uses_r2;
   logic [REG_W-1:0] r2_sel;
   logic             load_use;

   ex_stage_t  ex_q,  ex_d;
   mem_stage_t mem_q, mem_d;
   wb_stage_t  wb_q,  wb_d;

   // ---------------------------------------------------------------- decode
   // NOTE: every signal written here gets a default first, so that no path
   // through the casez leaves one unassigned and infers a latch.
   always_comb begin
      dec_ctrl    = '0;
      dec_reg2loc = 1'b0;
      dec_illegal = 1'b0;
      uses_rn     = 1'b0;
      uses_r2     = 1'b0;
      casez (Op)
         11'b1?0_0101_1000,                        // ADD / SUB
         11'b10?_0101_0000,                        // AND / ORR
         11'b1101_0110_000: begin
            dec_ctrl.reg_write = 1'b1;
            dec_ctrl.alu_op    = 2'b10;
            uses_rn            = 1'b1;
            uses_r2            = 1'b1;
         end
         11'b111_1100_0010: begin                  // LDUR
            dec_ctrl.mem_to_reg = 1'b1;
            dec_ctrl.reg_write  = 1'b1;
            dec_ctrl.mem_read   = 1'b1;
            dec_ctrl.alu_src    = 1'b1;
            uses_rn             = 1'b1;
         end
         11'b111_1100_0000: begin                  // STUR: Rt is the 2nd read
            dec_reg2loc        = 1'b1;
            dec_ctrl.mem_write = 1'b1;
            dec_ctrl.alu_src   = 1'b1;
            uses_rn            = 1'b1;
            uses_r2            = 1'b1;
         end
         11'b101_1010_0???: begin                  // CBZ
            dec_reg2loc     = 1'b1;
            dec_ctrl.branch = 1'b1;
            dec_ctrl.alu_op = 2'b01;
            uses_r2         = 1'b1;
         end
         11'b101_1010_1???: begin                  // CBNZ
            if (EXT_ISA) begin
               dec_reg2loc     = 1'b1;
               dec_ctrl.branch = 1'b1;
               dec_ctrl.alu_op = 2'b01;
               dec_ctrl.br_not = 1'b1;
               uses_r2         = 1'b1;
            end else begin
               dec_illegal = 1'b1;
            end
         end
         11'b000_101?_????: begin                  // B
            if (EXT_ISA) begin
               dec_ctrl.branch = 1'b1;
               dec_ctrl.uncond = 1'b1;
            end else begin
               dec_illegal = 1'b1;
            end
         end
         11'b100_1000_100?,                        // ADDI
         11'b110_1000_100?: begin                  // SUBI
            if (EXT_ISA) begin
               dec_ctrl.reg_write = 1'b1;
               dec_ctrl.alu_src   = 1'b1;
               dec_ctrl.alu_op    = 2'b10;
               uses_rn            = 1'b1;
            end else begin
               dec_illegal = 1'b1;
            end
         end
         default: dec_illegal = 1'b1;
      endcase
   end

   assign Reg2Loc = dec_reg2loc;

   // ---------------------------------------------------------------- hazard
   // The second read port is compared against whichever field Reg2Loc
   // steers into it, so STUR/CBZ match on Rt rather than Rm.
   assign r2_sel   = dec_reg2loc ? id_rd : id_rm;
   assign load_use = ex_q.ctrl.mem_read && (ex_q.rd != ZR) &&
                     ((uses_rn && (ex_q.rd == id_rn)) ||
                      (uses_r2 && (ex_q.rd == r2_sel)));

   // A flush discards the dependent instruction anyway, so flush wins.
   assign stall = STALL_EN && load_use && !flush && !reset;

   // ------------------------------------------------------------- next state
   always_comb begin
      ex_d  = (stall || flush) ? EX_BUBBLE
                               : '{ctrl: dec_ctrl, rd: id_rd, illegal: dec_illegal};
      mem_d = flush ? MEM_BUBBLE
                    : '{mem_to_reg: ex_q.ctrl.mem_to_reg,
                        reg_write:  ex_q.ctrl.reg_write,
                        mem_read:   ex_q.ctrl.mem_read,
                        mem_write:  ex_q.ctrl.mem_write,
                        branch:     ex_q.ctrl.branch,
                        uncond:     ex_q.ctrl.uncond,
                        br_not:     ex_q.ctrl.br_not,
                        rd:         ex_q.rd};
      // The branch sitting in MEM still retires; it has no WB effect.
      wb_d  = '{mem_to_reg: mem_q.mem_to_reg,
                reg_write:  mem_q.reg_write,
                rd:         mem_q.rd};
   end

   // NOTE: all three stage registers are reset to a bubble because the
   // control they hold has side effects (register and memory writes).
   // Non-blocking assignment lets every stage sample the old value of the
   // stage before it on the same edge.
   always_ff @(posedge clk) begin
      if (reset) begin
         ex_q  <= EX_BUBBLE;
         mem_q <= MEM_BUBBLE;
         wb_q  <= WB_BUBBLE;
      end else begin
         ex_q  <= ex_d;
         mem_q <= mem_d;
         wb_q  <= wb_d;
      end
   end

   // ---------------------------------------------------------------- outputs
   assign ex_ALUSrc    = ex_q.ctrl.alu_src;
   assign ex_ALUOp     = ex_q.ctrl.alu_op;
   assign ex_MemRead   = ex_q.ctrl.mem_read;
   assign ex_rd        = ex_q.rd;
   assign illegal      = ex_q.illegal;

   assign mem_MemRead  = mem_q.mem_read;
   assign mem_MemWrite = mem_q.mem_write;
   assign mem_Branch   = mem_q.branch;
   assign mem_Uncond   = mem_q.uncond;
   assign mem_BrNot    = mem_q.br_not;
   assign mem_rd       = mem_q.rd;

   assign wb_RegWrite  = wb_q.reg_write;
   assign wb_MemtoReg  = wb_q.mem_to_reg;
   assign wb_rd        = wb_q.rd;

endmodule
